// File: rtl/rv64_instr_decoder_pkg.sv
// Shared types for the RV64I decoder: decoded op enum, major opcodes, immediate formats.
// Ops are decoded for the M extension only when the build defines RV64_MEXT_EN.
package rv64_decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_OP_IMM32 = 7'h1B;
    localparam logic [6:0] OPC_OP32     = 7'h3B;
    localparam logic [6:0] OPC_FENCE    = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    // SH6/SH5 are the zero-extended shift amounts of the 64-bit and word shifts.
    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SH6,
        IMM_SH5
    } imm_fmt_e;

    typedef enum logic [6:0] {
        OP_NONE    = 7'd0,
        OP_ILLEGAL = 7'd1,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } op_e;

endpackage

// File: rtl/rv64_instr_decoder_if.sv
// Fetch-to-decoder bundle: instruction/PC in, registered decode results out.
// The master modport is the fetch/consumer side, the slave modport is the decoder.
interface rv64_instr_decoder_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) ();
    logic            in_valid;
    logic [ILEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_op;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;
    logic            out_zero;

    modport master (
        output in_valid, in_instr, in_pc,
        input  out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_funct3, out_imm, out_illegal, out_zero
    );

    modport slave (
        input  in_valid, in_instr, in_pc,
        output out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_funct3, out_imm, out_illegal, out_zero
    );
endinterface

// File: rtl/rv64_instr_decoder_imm_gen.sv
// Combinational immediate generator: selects and sign-extends the immediate of the given format.
// Only instr[31:7] carries immediate bits, so the opcode field is not an input.
module rv64_imm_gen
    import rv64_decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:7]     i_instr,
    input  imm_fmt_e        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic w_sign;
    assign w_sign = i_instr[31];

    always_comb begin
        o_imm = '0;
        case (i_fmt)
            IMM_I:   o_imm = {{(XLEN-12){w_sign}}, i_instr[31:20]};
            IMM_S:   o_imm = {{(XLEN-12){w_sign}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   o_imm = {{(XLEN-13){w_sign}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   o_imm = {{(XLEN-32){w_sign}}, i_instr[31:12], 12'b0};
            IMM_J:   o_imm = {{(XLEN-21){w_sign}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            IMM_SH6: o_imm = {{(XLEN-6){1'b0}}, i_instr[25:20]};
            IMM_SH5: o_imm = {{(XLEN-5){1'b0}}, i_instr[24:20]};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/rv64_instr_decoder.sv
// Registered RV64I instruction decoder (1-cycle latency, no backpressure).
// Define RV64_MEXT_EN to decode the M extension on OP/OP-32; otherwise those encodings are illegal.
module rv64_instr_decoder
    import rv64_decode_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input logic                  clk,
    input logic                  reset,
    rv64_instr_decoder_if.slave  dec
);

    logic [ILEN-1:0] w_instr;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    op_e             w_op;
    imm_fmt_e        w_fmt;
    imm_fmt_e        w_fmtEff;
    logic            w_useRd;
    logic            w_useRs1;
    logic            w_useRs2;
    logic            w_illegal;
    logic            w_zero;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    op_e             r_op;
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_imm;
    logic            r_illegal;
    logic            r_zero;

    assign w_instr  = dec.in_instr;
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];
    assign w_funct7 = w_instr[31:25];

    // w_op stays OP_ILLEGAL unless a fully legal encoding is recognised.
    always_comb begin
        w_op     = OP_ILLEGAL;
        w_fmt    = IMM_NONE;
        w_useRd  = 1'b0;
        w_useRs1 = 1'b0;
        w_useRs2 = 1'b0;
        if (w_instr[1:0] == 2'b11) begin
            case (w_opcode)
                OPC_LUI: begin
                    w_op = OP_LUI;   w_fmt = IMM_U; w_useRd = 1'b1;
                end
                OPC_AUIPC: begin
                    w_op = OP_AUIPC; w_fmt = IMM_U; w_useRd = 1'b1;
                end
                OPC_JAL: begin
                    w_op = OP_JAL;   w_fmt = IMM_J; w_useRd = 1'b1;
                end
                OPC_JALR: begin
                    w_fmt = IMM_I; w_useRd = 1'b1; w_useRs1 = 1'b1;
                    if (w_funct3 == 3'b000) w_op = OP_JALR;
                end
                OPC_BRANCH: begin
                    w_fmt = IMM_B; w_useRs1 = 1'b1; w_useRs2 = 1'b1;
                    case (w_funct3)
                        3'b000:  w_op = OP_BEQ;
                        3'b001:  w_op = OP_BNE;
                        3'b100:  w_op = OP_BLT;
                        3'b101:  w_op = OP_BGE;
                        3'b110:  w_op = OP_BLTU;
                        3'b111:  w_op = OP_BGEU;
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_LOAD: begin
                    w_fmt = IMM_I; w_useRd = 1'b1; w_useRs1 = 1'b1;
                    case (w_funct3)
                        3'b000:  w_op = OP_LB;
                        3'b001:  w_op = OP_LH;
                        3'b010:  w_op = OP_LW;
                        3'b011:  w_op = OP_LD;
                        3'b100:  w_op = OP_LBU;
                        3'b101:  w_op = OP_LHU;
                        3'b110:  w_op = OP_LWU;
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_STORE: begin
                    w_fmt = IMM_S; w_useRs1 = 1'b1; w_useRs2 = 1'b1;
                    case (w_funct3)
                        3'b000:  w_op = OP_SB;
                        3'b001:  w_op = OP_SH;
                        3'b010:  w_op = OP_SW;
                        3'b011:  w_op = OP_SD;
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_OP_IMM: begin
                    w_fmt = IMM_I; w_useRd = 1'b1; w_useRs1 = 1'b1;
                    case (w_funct3)
                        3'b000: w_op = OP_ADDI;
                        3'b010: w_op = OP_SLTI;
                        3'b011: w_op = OP_SLTIU;
                        3'b100: w_op = OP_XORI;
                        3'b110: w_op = OP_ORI;
                        3'b111: w_op = OP_ANDI;
                        3'b001: begin
                            w_fmt = IMM_SH6;
                            if (w_instr[31:26] == 6'b000000) w_op = OP_SLLI;
                        end
                        3'b101: begin
                            w_fmt = IMM_SH6;
                            if (w_instr[31:26] == 6'b000000)      w_op = OP_SRLI;
                            else if (w_instr[31:26] == 6'b010000) w_op = OP_SRAI;
                        end
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                // Word shifts only have a 5-bit shamt, so instr[25] is part of funct7 here.
                OPC_OP_IMM32: begin
                    w_fmt = IMM_I; w_useRd = 1'b1; w_useRs1 = 1'b1;
                    case (w_funct3)
                        3'b000: w_op = OP_ADDIW;
                        3'b001: begin
                            w_fmt = IMM_SH5;
                            if (w_funct7 == 7'b0000000) w_op = OP_SLLIW;
                        end
                        3'b101: begin
                            w_fmt = IMM_SH5;
                            if (w_funct7 == 7'b0000000)      w_op = OP_SRLIW;
                            else if (w_funct7 == 7'b0100000) w_op = OP_SRAIW;
                        end
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_OP: begin
                    w_useRd = 1'b1; w_useRs1 = 1'b1; w_useRs2 = 1'b1;
                    case (w_funct7)
                        7'b0000000: begin
                            case (w_funct3)
                                3'b000:  w_op = OP_ADD;
                                3'b001:  w_op = OP_SLL;
                                3'b010:  w_op = OP_SLT;
                                3'b011:  w_op = OP_SLTU;
                                3'b100:  w_op = OP_XOR;
                                3'b101:  w_op = OP_SRL;
                                3'b110:  w_op = OP_OR;
                                default: w_op = OP_AND;
                            endcase
                        end
                        7'b0100000: begin
                            if (w_funct3 == 3'b000)      w_op = OP_SUB;
                            else if (w_funct3 == 3'b101) w_op = OP_SRA;
                        end
`ifdef RV64_MEXT_EN
                        7'b0000001: begin
                            case (w_funct3)
                                3'b000:  w_op = OP_MUL;
                                3'b001:  w_op = OP_MULH;
                                3'b010:  w_op = OP_MULHSU;
                                3'b011:  w_op = OP_MULHU;
                                3'b100:  w_op = OP_DIV;
                                3'b101:  w_op = OP_DIVU;
                                3'b110:  w_op = OP_REM;
                                default: w_op = OP_REMU;
                            endcase
                        end
`endif
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_OP32: begin
                    w_useRd = 1'b1; w_useRs1 = 1'b1; w_useRs2 = 1'b1;
                    case (w_funct7)
                        7'b0000000: begin
                            if (w_funct3 == 3'b000)      w_op = OP_ADDW;
                            else if (w_funct3 == 3'b001) w_op = OP_SLLW;
                            else if (w_funct3 == 3'b101) w_op = OP_SRLW;
                        end
                        7'b0100000: begin
                            if (w_funct3 == 3'b000)      w_op = OP_SUBW;
                            else if (w_funct3 == 3'b101) w_op = OP_SRAW;
                        end
`ifdef RV64_MEXT_EN
                        7'b0000001: begin
                            case (w_funct3)
                                3'b000:  w_op = OP_MULW;
                                3'b100:  w_op = OP_DIVW;
                                3'b101:  w_op = OP_DIVUW;
                                3'b110:  w_op = OP_REMW;
                                3'b111:  w_op = OP_REMUW;
                                default: w_op = OP_ILLEGAL;
                            endcase
                        end
`endif
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                // FENCE reports its fm/pred/succ field through the I immediate.
                OPC_FENCE: begin
                    w_fmt = IMM_I;
                    if (w_funct3 == 3'b000) w_op = OP_FENCE;
                end
                OPC_SYSTEM: begin
                    if (w_instr[31:7] == 25'h0000000)      w_op = OP_ECALL;
                    else if (w_instr[31:7] == 25'h0002000) w_op = OP_EBREAK;
                end
                default: w_op = OP_ILLEGAL;
            endcase
        end
    end

    assign w_illegal = (w_op == OP_ILLEGAL);
    assign w_zero    = (w_instr == '0);
    assign w_fmtEff  = w_illegal ? IMM_NONE : w_fmt;
    assign w_rd      = (w_useRd  && !w_illegal) ? w_instr[11:7]  : 5'd0;
    assign w_rs1     = (w_useRs1 && !w_illegal) ? w_instr[19:15] : 5'd0;
    assign w_rs2     = (w_useRs2 && !w_illegal) ? w_instr[24:20] : 5'd0;

    rv64_imm_gen #(
        .XLEN (XLEN)
    ) u_immGen (
        .i_instr (w_instr[31:7]),
        .i_fmt   (w_fmtEff),
        .o_imm   (w_imm)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_op      <= OP_NONE;
            r_rd      <= 5'd0;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_funct3  <= 3'd0;
            r_imm     <= '0;
            r_illegal <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            r_valid <= dec.in_valid;
            if (dec.in_valid) begin
                r_pc      <= dec.in_pc;
                r_op      <= w_op;
                r_rd      <= w_rd;
                r_rs1     <= w_rs1;
                r_rs2     <= w_rs2;
                r_funct3  <= w_funct3;
                r_imm     <= w_imm;
                r_illegal <= w_illegal;
                r_zero    <= w_zero;
            end
        end
    end

    assign dec.out_valid   = r_valid;
    assign dec.out_pc      = r_pc;
    assign dec.out_op      = r_op;
    assign dec.out_rd      = r_rd;
    assign dec.out_rs1     = r_rs1;
    assign dec.out_rs2     = r_rs2;
    assign dec.out_funct3  = r_funct3;
    assign dec.out_imm     = r_imm;
    assign dec.out_illegal = r_illegal;
    assign dec.out_zero    = r_zero;

endmodule

// File: tb/tb_rv64_instr_decoder.sv
// Scoreboard bench for rv64_instr_decoder: hand-computed expectations are queued when a word is
// driven and compared when out_valid shows up; also covers reset state, hold, and mid-stream reset.
module tb_rv64_instr_decoder;
    import rv64_decode_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [63:0] imm;
        logic        illegal;
        logic        zero;
    } expect_t;

    logic clk = 1'b0;
    logic reset;
    logic expValid;
    logic [63:0] lastPc;
    int totalCount = 0;
    int badCount = 0;
    expect_t sb[$];

    rv64_instr_decoder_if bus ();

    rv64_instr_decoder dut (
        .clk   (clk),
        .reset (reset),
        .dec   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s observed=%h required=%h", tag, observed, expected);
        end
    endtask

    // Drive one word for one cycle and queue what the decoder must report for it.
    task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] pc, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [63:0] imm);
        expect_t e;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        e.instr   = instr;
        e.pc      = pc;
        e.op      = op;
        e.rd      = rd;
        e.rs1     = rs1;
        e.rs2     = rs2;
        e.funct3  = instr[14:12];
        e.imm     = imm;
        e.illegal = (op == OP_ILLEGAL);
        e.zero    = (instr == 32'h0);
        sb.push_back(e);
        lastPc = pc;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Independent view of when output must be valid: one cycle after in_valid, cleared by reset.
    always @(posedge clk or posedge reset) begin
        if (reset) expValid <= 1'b0;
        else       expValid <= bus.in_valid;
    end

    always @(negedge clk) begin
        expect_t e;
        if (!reset) begin
            checkOutput("validLatency", {63'd0, bus.out_valid}, {63'd0, expValid});
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("sbEmpty", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("pc_%h", e.instr),      bus.out_pc, e.pc);
                    checkOutput($sformatf("op_%h", e.instr),      {57'd0, bus.out_op}, {57'd0, e.op});
                    checkOutput($sformatf("rd_%h", e.instr),      {59'd0, bus.out_rd}, {59'd0, e.rd});
                    checkOutput($sformatf("rs1_%h", e.instr),     {59'd0, bus.out_rs1}, {59'd0, e.rs1});
                    checkOutput($sformatf("rs2_%h", e.instr),     {59'd0, bus.out_rs2}, {59'd0, e.rs2});
                    checkOutput($sformatf("funct3_%h", e.instr),  {61'd0, bus.out_funct3}, {61'd0, e.funct3});
                    checkOutput($sformatf("imm_%h", e.instr),     bus.out_imm, e.imm);
                    checkOutput($sformatf("illegal_%h", e.instr), {63'd0, bus.out_illegal}, {63'd0, e.illegal});
                    checkOutput($sformatf("zero_%h", e.instr),    {63'd0, bus.out_zero}, {63'd0, e.zero});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", totalCount, badCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'h0;
        bus.in_pc    = 64'h0;
        lastPc       = 64'h0;
        #2;
        checkOutput("rstValid",   {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rstOp",      {57'd0, bus.out_op}, {57'd0, 7'(OP_NONE)});
        checkOutput("rstPc",      bus.out_pc, 64'd0);
        checkOutput("rstImm",     bus.out_imm, 64'd0);
        checkOutput("rstIllegal", {63'd0, bus.out_illegal}, 64'd0);
        checkOutput("rstZero",    {63'd0, bus.out_zero}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] decode table");
        applyStimulus(32'hFFF00093, 64'h1000, OP_ADDI,  5'd1, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFF);
        applyStimulus(32'h123452B7, 64'h1004, OP_LUI,   5'd5, 5'd0, 5'd0, 64'h0000000012345000);
        applyStimulus(32'h800002B7, 64'h1008, OP_LUI,   5'd5, 5'd0, 5'd0, 64'hFFFFFFFF80000000);
        applyStimulus(32'h00208463, 64'h100C, OP_BEQ,   5'd0, 5'd1, 5'd2, 64'd8);
        applyStimulus(32'h0020B423, 64'h1010, OP_SD,    5'd0, 5'd1, 5'd2, 64'd8);
        applyStimulus(32'h43F0D093, 64'h1014, OP_SRAI,  5'd1, 5'd1, 5'd0, 64'd63);
        applyStimulus(32'h43F0D09B, 64'h1018, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 64'd0);
        applyStimulus(32'h00000000, 64'h101C, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 64'd0);
`ifdef RV64_MEXT_EN
        applyStimulus(32'h02208033, 64'h1020, OP_MUL,   5'd0, 5'd1, 5'd2, 64'd0);
`else
        applyStimulus(32'h02208033, 64'h1020, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 64'd0);
`endif
        applyStimulus(32'hFFFFFFFF, 64'h1024, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 64'd0);
        applyStimulus(32'h402081B3, 64'h1028, OP_SUB,   5'd3, 5'd1, 5'd2, 64'd0);
        applyStimulus(32'h010000EF, 64'h102C, OP_JAL,   5'd1, 5'd0, 5'd0, 64'd16);
        applyStimulus(32'hFFDFF0EF, 64'h1030, OP_JAL,   5'd1, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFC);
        applyStimulus(32'hFF812203, 64'h1034, OP_LW,    5'd4, 5'd2, 5'd0, 64'hFFFFFFFFFFFFFFF8);
        applyStimulus(32'h00007003, 64'h1038, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 64'd0);
        applyStimulus(32'h00004023, 64'h103C, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 64'd0);
        applyStimulus(32'h00001067, 64'h1040, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 64'd0);
        applyStimulus(32'h00008067, 64'h1044, OP_JALR,  5'd0, 5'd1, 5'd0, 64'd0);
        applyStimulus(32'h00000073, 64'h1048, OP_ECALL, 5'd0, 5'd0, 5'd0, 64'd0);
        applyStimulus(32'h00100073, 64'h104C, OP_EBREAK, 5'd0, 5'd0, 5'd0, 64'd0);
        applyStimulus(32'h01F0909B, 64'h1050, OP_SLLIW, 5'd1, 5'd1, 5'd0, 64'd31);
        applyStimulus(32'h00000090, 64'h1054, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 64'd0);
        applyStimulus(32'hFE20AE23, 64'h1058, OP_SW,    5'd0, 5'd1, 5'd2, 64'hFFFFFFFFFFFFFFFC);
        applyStimulus(32'h00001197, 64'h105C, OP_AUIPC, 5'd3, 5'd0, 5'd0, 64'h1000);
        applyStimulus(32'h0FF0000F, 64'h1060, OP_FENCE, 5'd0, 5'd0, 5'd0, 64'h0FF);

        // Fields must hold their last decode while in_valid is low.
        idleCycle();
        @(posedge clk);
        #1;
        checkOutput("holdValid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("holdPc",    bus.out_pc, lastPc);
        checkOutput("holdOp",    {57'd0, bus.out_op}, {57'd0, 7'(OP_FENCE)});

        $display("[TB] mid-stream reset");
        applyStimulus(32'h00100093, 64'h2000, OP_ADDI, 5'd1, 5'd0, 5'd0, 64'd1);
        applyStimulus(32'h00208113, 64'h2004, OP_ADDI, 5'd2, 5'd1, 5'd0, 64'd2);
        applyStimulus(32'h00310193, 64'h2008, OP_ADDI, 5'd3, 5'd2, 5'd0, 64'd3);
        #5;
        reset = 1'b1;
        #1;
        checkOutput("midRstValid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("midRstOp",    {57'd0, bus.out_op}, {57'd0, 7'(OP_NONE)});
        checkOutput("midRstPc",    bus.out_pc, 64'd0);
        checkOutput("midRstRd",    {59'd0, bus.out_rd}, 64'd0);
        checkOutput("midRstImm",   bus.out_imm, 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        bus.in_instr = 32'h00418213;
        bus.in_pc    = 64'h200C;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("postRstIdle", {63'd0, bus.out_valid}, 64'd0);
        applyStimulus(32'h00500113, 64'h3000, OP_ADDI, 5'd2, 5'd0, 5'd0, 64'd5);
        idleCycle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        checkOutput("sbDrain", 64'(sb.size()), 64'd0);
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/rv64_instr_decoder.md
Name: rv64_instr_decoder

Overview:
- Registered RV64I instruction decoder between the fetch unit and the execute/trace stage.
- Accepts one 32-bit instruction word plus its PC per cycle.
- Produces a decoded op code, register indices, a sign-extended XLEN immediate and status flags one cycle later.
- Fetch splits each 64-bit bus beat into two 32-bit words and presents them back to back; an all-zero word marks end of program.

Parameters:
- XLEN, 64, datapath/PC/immediate width.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_instr/in_pc valid this cycle.
- in_instr  in  ILEN  raw instruction word.
- in_pc  in  XLEN  address of in_instr.
- out_valid  out  1  decoded outputs valid.
- out_pc  out  XLEN  registered copy of in_pc.
- out_op  out  7  op_e enum value.
- out_rd  out  5  destination register; 0 if the op writes none.
- out_rs1  out  5  source 1; 0 if unused.
- out_rs2  out  5  source 2; 0 if unused.
- out_funct3  out  3  instr[14:12].
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type.
- out_illegal  out  1  unrecognised encoding.
- out_zero  out  1  instruction word == 0 (halt marker).

Behaviour:
- Interface decided: one clock, clk; reset is asynchronous and active-high, port named reset.
- Reset: all outputs 0; out_op = OP_NONE (0). Reset asserted mid-stream discards the in-flight decode; first out_valid comes 1 cycle after the first in_valid following reset release.
- Latency 1: each posedge registers out_valid <= in_valid.
- Fields update only when in_valid=1; otherwise hold previous values.
- No backpressure: one decode per cycle, consecutive words fully independent.

Immediates (sign bit instr[31] extended to XLEN):
- I: instr[31:20].
- S: {[31:25],[11:7]}.
- B: {[31],[7],[30:25],[11:8],0}.
- U: {[31:12],12'b0}, sign-extended.
- J: {[31],[19:12],[20],[30:21],0}.
- Shift-immediates: out_imm = zero-extended shamt.
  - SLLI/SRLI/SRAI: 6-bit shamt; funct6 must be 000000 or 010000 (SRAI).
  - SLLIW/SRLIW/SRAIW: 5-bit shamt; instr[25]=1 is illegal.

Decoded classes:
- LUI, AUIPC, JAL, JALR.
- BEQ/BNE/BLT/BGE/BLTU/BGEU.
- LB/LH/LW/LD/LBU/LHU/LWU.
- SB/SH/SW/SD.
- OP-IMM, OP, OP-IMM-32, OP-32 (all legal funct3/funct7 combinations).
- FENCE, ECALL, EBREAK.

Illegal (out_illegal=1, out_op=OP_ILLEGAL, rd/rs1/rs2/imm=0):
- instr[1:0] != 2'b11.
- Unknown opcode, funct3 or funct7.
- JALR funct3 != 0.
- Load funct3 = 111.
- Store funct3 >= 100.
- Zero word: out_zero=1 and out_illegal=1.
- All-ones word: illegal, out_zero=0.

Optional Feature:
- Macro RV64_MEXT_EN.
- Defined: funct7=0000001 on OP/OP-32 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU/MULW/DIVW/DIVUW/REMW/REMUW to their op_e values.
- Undefined: those encodings are illegal. The enum values exist either way.

Decomposition:
- Package rv64_decode_pkg: op_e enum (OP_NONE=0, OP_ILLEGAL=1, then all ops), opcode localparams (7'h37 LUI, 7'h17 AUIPC, 7'h6F JAL, 7'h67 JALR, 7'h63 BRANCH, 7'h03 LOAD, 7'h23 STORE, 7'h13 OP_IMM, 7'h33 OP, 7'h1B OP_IMM32, 7'h3B OP32, 7'h0F FENCE, 7'h73 SYSTEM), imm-format enum.
- Sub-module rv64_imm_gen: combinational immediate generator (instr + format -> XLEN imm).

Test Plan:
- 0xFFF00093 (ADDI x1,x0,-1), pc=0x1000 -> next cycle: out_op=ADDI, rd=1, rs1=0, imm=0xFFFFFFFFFFFFFFFF, out_pc=0x1000, illegal=0.
- 0x123452B7 -> LUI rd=5, imm=0x0000000012345000; 0x800002B7 -> imm=0xFFFFFFFF80000000.
- 0x00208463 -> BEQ rs1=1, rs2=2, rd=0, imm=8; 0x0020B423 -> SD rs1=1, rs2=2, imm=8.
- 0x43F0D093 -> SRAI rd=1, rs1=1, imm=63; same with instr[25]=1 on opcode 0x1B -> illegal.
- 0x00000000 -> out_zero=1, out_illegal=1; 0x02208033 (MUL) -> MUL with RV64_MEXT_EN, illegal without.
- Back-to-back words at pc and pc+4 for 4 cycles with reset asserted in cycle 3 -> outputs 0 asynchronously, out_valid=0; first valid output 1 cycle after the next in_valid following release.
